// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-fed UART transmitter with per-frame divisor, parity and stop-bit settings.
// Settings and data are captured in the pop cycle and held for the whole frame.
module uart_tx_engine #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned       BIT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DIV_WIDTH-1:0]  r_div;
  logic [DIV_WIDTH-1:0]  r_baud_cnt;
  logic [BIT_W-1:0]      r_bit_idx;
  logic                  r_parity_en;
  logic                  r_par_bit;
  logic                  r_stop2;
  logic                  r_stop_idx;
  logic                  r_txd;
  logic                  r_busy;
  logic                  r_tx_done;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [DIV_WIDTH-1:0]  w_div_nxt;
  logic [DIV_WIDTH-1:0]  w_baud_nxt;
  logic [BIT_W-1:0]      w_bit_idx_nxt;
  logic                  w_parity_en_nxt;
  logic                  w_par_bit_nxt;
  logic                  w_stop2_nxt;
  logic                  w_stop_idx_nxt;
  logic                  w_txd_nxt;
  logic                  w_busy_nxt;
  logic                  w_tx_done_nxt;
  logic                  w_pop;
  logic                  w_bit_end;

  // Pop is gated by rst_n so the FIFO is never drained while the engine is held in reset.
  assign w_pop     = (r_state == IDLE) && enable && !fifo_empty && rst_n;
  assign w_bit_end = (r_baud_cnt == r_div);

  // Next-state, datapath and output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_div_nxt       = r_div;
    w_baud_nxt      = w_bit_end ? '0 : r_baud_cnt + DIV_WIDTH'(1);
    w_bit_idx_nxt   = r_bit_idx;
    w_parity_en_nxt = r_parity_en;
    w_par_bit_nxt   = r_par_bit;
    w_stop2_nxt     = r_stop2;
    w_stop_idx_nxt  = r_stop_idx;
    w_txd_nxt       = 1'b1;
    w_busy_nxt      = 1'b0;
    w_tx_done_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        if (w_pop) begin
          w_state_nxt     = START;
          w_shift_nxt     = fifo_dout;
          w_div_nxt       = baud_div;
          w_parity_en_nxt = parity_en;
          w_par_bit_nxt   = (^fifo_dout) ^ parity_odd;
          w_stop2_nxt     = stop2;
          w_bit_idx_nxt   = '0;
          w_stop_idx_nxt  = 1'b0;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == LAST_BIT) begin
            w_state_nxt = r_parity_en ? PARITY : STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_stop_idx == r_stop2) begin
            w_state_nxt   = IDLE;
            w_tx_done_nxt = 1'b1;
          end else begin
            w_stop_idx_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Line level follows the state being entered so txd lines up with the state register.
    unique case (w_state_nxt)
      START:   w_txd_nxt = 1'b0;
      DATA:    w_txd_nxt = w_shift_nxt[0];
      PARITY:  w_txd_nxt = r_par_bit;
      default: w_txd_nxt = 1'b1;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_div       <= '0;
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_parity_en <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop2     <= 1'b0;
      r_stop_idx  <= 1'b0;
      r_txd       <= 1'b1;
      r_busy      <= 1'b0;
      r_tx_done   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_div       <= w_div_nxt;
      r_baud_cnt  <= w_baud_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_parity_en <= w_parity_en_nxt;
      r_par_bit   <= w_par_bit_nxt;
      r_stop2     <= w_stop2_nxt;
      r_stop_idx  <= w_stop_idx_nxt;
      r_txd       <= w_txd_nxt;
      r_busy      <= w_busy_nxt;
      r_tx_done   <= w_tx_done_nxt;
    end
  end

  assign fifo_rd_en = w_pop;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign tx_done    = r_tx_done;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: FIFO model plus per-cycle line scoreboard, a vector table of frame
// settings, and hand-written sequences for back-to-back, enable, reset and divisor-change cases.
module tb_uart_tx_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 16;

  typedef struct packed {
    logic txd;
    logic busy;
    logic done;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        pe;
    logic        po;
    logic        s2;
    logic        exp_bit9;
    int          exp_len;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [VW-1:0] baud_div;
  logic          parity_en;
  logic          parity_odd;
  logic          stop2;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic          txd;
  logic          busy;
  logic          tx_done;

  logic [7:0] fifo_mem [256];
  int         wr_ptr  = 0;
  int         rd_ptr  = 0;
  int         cyc     = 0;
  int         n_total = 0;
  int         n_bad   = 0;
  exp_t       exp_q [$];
  exp_t       mon_e;
  vec_t       vecs [8];

  uart_tx_engine #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .txd        (txd),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  assign fifo_dout  = fifo_mem[rd_ptr[7:0]];
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
  end

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    fifo_mem[wr_ptr[7:0]] = d;
    wr_ptr++;
  endtask

  // Expected line samples for one frame, one entry per clock, then the done cycle.
  task automatic push_frame(input logic [7:0] d, input int div, input logic pe,
                            input logic po, input logic s2);
    logic b [12];
    int   nb;
    exp_t e;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = d[i];
    nb = 9;
    if (pe) begin
      b[nb] = (^d) ^ po;
      nb = nb + 1;
    end
    b[nb] = 1'b1;
    nb = nb + 1;
    if (s2) begin
      b[nb] = 1'b1;
      nb = nb + 1;
    end
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j <= div; j++) begin
        e.txd  = b[i];
        e.busy = 1'b1;
        e.done = 1'b0;
        exp_q.push_back(e);
      end
    end
    e.txd  = 1'b1;
    e.busy = 1'b0;
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Scoreboard: compare every cycle, queue a frame whenever a pop is seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("reset_outputs", int'({txd, busy, tx_done, fifo_rd_en}), 8);
    end else begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
      end else begin
        mon_e.txd  = 1'b1;
        mon_e.busy = 1'b0;
        mon_e.done = 1'b0;
      end
      check("line_txd_busy_done", int'({txd, busy, tx_done}), int'(mon_e));
      if (fifo_rd_en) begin
        check("pop_during_frame", exp_q.size(), 0);
        push_frame(fifo_dout, int'(baud_div), parity_en, parity_odd, stop2);
      end
    end
  end

  task automatic wait_pop(output int t);
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (fifo_rd_en) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("pop_timeout", 0, 1);
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_done) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    int tp, td, t1, t2, cnt;
    vecs[0] = '{8'hA5, 16'd3, 1'b0, 1'b0, 1'b0, 1'b1, 41};
    vecs[1] = '{8'h07, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1, 23};
    vecs[2] = '{8'h07, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0, 23};
    vecs[3] = '{8'h00, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0, 13};
    vecs[4] = '{8'hFF, 16'd2, 1'b1, 1'b1, 1'b0, 1'b1, 34};
    vecs[5] = '{8'h3C, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 56};
    vecs[6] = '{8'h81, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 12};
    vecs[7] = '{8'h01, 16'd5, 1'b1, 1'b1, 1'b1, 1'b0, 73};

    rst_n      = 1'b1;
    enable     = 1'b0;
    baud_div   = '0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", tx_done, 0);

    // Table: per-frame settings, bit after the data field, pop-to-done clocks.
    @(posedge clk); #1 enable = 1'b1;
    for (int r = 0; r < 8; r++) begin
      @(posedge clk); #1;
      baud_div   = vecs[r].div;
      parity_en  = vecs[r].pe;
      parity_odd = vecs[r].po;
      stop2      = vecs[r].s2;
      push_word(vecs[r].data);
      wait_pop(tp);
      repeat (9 * (int'(vecs[r].div) + 1) + 1) @(negedge clk);
      check("bit_after_data", txd, vecs[r].exp_bit9);
      wait_done(td);
      check("pop_to_done", td - tp, vecs[r].exp_len);
    end

    // Back-to-back frames at one-clock bits with two stop bits.
    @(posedge clk); #1;
    baud_div  = '0;
    parity_en = 1'b0;
    stop2     = 1'b1;
    push_word(8'h00);
    push_word(8'hFF);
    wait_pop(t1);
    repeat (9) @(negedge clk);
    check("zero_word_last_low", txd, 0);
    @(negedge clk);
    check("zero_word_first_stop", txd, 1);
    wait_pop(t2);
    check("back_to_back_spacing", t2 - t1, 12);
    wait_done(td);

    // Empty FIFO, then disabled engine: no pops.
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en) cnt++;
    end
    check("empty_no_pop", cnt, 0);
    @(posedge clk); #1;
    enable   = 1'b0;
    baud_div = 16'd1;
    stop2    = 1'b0;
    push_word(8'h5A);
    push_word(8'h96);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd_en) cnt++;
    end
    check("disabled_no_pop", cnt, 0);
    @(posedge clk); #1 enable = 1'b1;
    wait_pop(tp);
    @(posedge clk); #1 enable = 1'b0;
    wait_done(td);
    check("disabled_frame_len", td - tp, 21);
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_rd_en) cnt++;
    end
    check("no_pop_after_disable", cnt, 0);
    check("fifo_level_kept", wr_ptr - rd_ptr, 1);
    @(posedge clk); #1 enable = 1'b1;
    wait_pop(tp);
    wait_done(td);

    // Reset during the 4th data bit, then the next word pops right away.
    @(posedge clk); #1;
    baud_div = 16'd3;
    push_word(8'hA5);
    push_word(8'h3C);
    wait_pop(tp);
    repeat (18) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_txd", txd, 1);
    check("async_busy", busy, 0);
    check("rd_en_in_reset", fifo_rd_en, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("pop_after_reset", fifo_rd_en, 1);
    tp = cyc;
    wait_done(td);
    check("post_reset_len", td - tp, 41);

    // Divisor changed mid-frame only affects the next frame.
    @(posedge clk); #1;
    baud_div = 16'd3;
    push_word(8'h3C);
    push_word(8'hC3);
    wait_pop(t1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1 baud_div = 16'd7;
    wait_pop(t2);
    check("frame_with_old_div", t2 - t1, 41);
    wait_done(td);
    check("frame_with_new_div", td - t2, 81);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
